avalon_mem_arbiter: RTL
=======================

// Module: avalon_mem_arbiter
// PURPOSE
//  Shares the single Avalon-MM master port of top_level_cpu between the instruction-fetch
//  requester and the load/store data requester. Sequences one bus transaction at a time,
//  honours waitrequest, and returns readdata plus a one-cycle done pulse to the winner.
//  Sits between the CPU datapath and the RAM / bus interconnect.
// PARAMETERS
//  ADDR_W        32    address width, byte addressed
//  DATA_W        32    data width; byteenable width is DATA_W/8
//  TIMEOUT_CYC   1024  max cycles waitrequest may stay high (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1         system clock, rising edge
//  reset        in   1         asynchronous, active-low reset
//  if_req       in   1         fetch request; held high until if_done
//  if_addr      in   ADDR_W    fetch address
//  if_done      out  1         one-cycle pulse, fetch complete
//  d_req        in   1         data request; held high until d_done
//  d_we         in   1         1 = write, 0 = read
//  d_addr       in   ADDR_W    data address
//  d_wdata      in   DATA_W    write data
//  d_be         in   DATA_W/8  byte enables
//  d_done       out  1         one-cycle pulse, data access complete
//  rdata        out  DATA_W    read data captured for the completing access; valid with *_done
//  address      out  ADDR_W    Avalon address
//  read/write   out  1 each    Avalon strobes, never both high
//  writedata    out  DATA_W    Avalon write data
//  byteenable   out  DATA_W/8  Avalon byte enables
//  waitrequest  in   1         Avalon stall
//  readdata     in   DATA_W    Avalon read data
//  busy         out  1         transaction in flight
// BEHAVIOUR
//  Reset (reset low, async): state IDLE, read=write=0, address=writedata=rdata=0,
//   byteenable=0, if_done=d_done=busy=0, last_grant=FETCH (so data wins first tie).
//  All outputs registered. States: IDLE, BUS, DONE.
//  IDLE: if any req at edge -> pick winner, load address/strobe/writedata/byteenable,
//   busy=1, -> BUS. Fetch reads use byteenable=4'hF. No req -> stay IDLE.
//  Arbitration: one req -> it wins. Both -> round-robin: winner != last_grant; update last_grant.
//  BUS: strobes held, all bus outputs stable while waitrequest=1. At edge with waitrequest=0:
//   drop strobes, rdata<=readdata (reads only; writes leave rdata unchanged),
//   pulse winner's done, -> DONE.
//  DONE: done pulse ends, busy=0, -> IDLE. Min latency req->done = 2 cycles with
//   zero-wait slave; at least one idle bus cycle between transactions.
//  Req dropped during BUS: transaction still completes, done still pulses (no abort).
//  Req changing address during BUS: ignored; latched values are used.
//  A requester that keeps req high after done is re-arbitrated in IDLE as a new request.
//  Reset asserted mid-BUS: strobes drop immediately; no done pulse.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: wait counter runs in BUS; if waitrequest stays high for
//   TIMEOUT_CYC cycles, strobes drop, rdata<=32'hDEADBEEF, done pulses, extra output
//   bus_err goes high, stays high (sticky) until reset.
//  Not defined: no counter, no bus_err port; BUS waits indefinitely.
// STRUCTURE
//  Package mem_arb_pkg: state enum {IDLE,BUS,DONE}, grant enum {GNT_FETCH,GNT_DATA},
//   BE_ALL constant, DEADBEEF error constant.
//  Sub-module arb_rr2: 2-way round-robin picker (req[1:0], last_grant -> grant).
// TESTING
//  Fetch only, 0-wait RAM, mem[0x04]=32'h24020010 -> address=0x04, read=1 one cycle;
//   if_done 2 cycles after if_req, rdata=32'h24020010.
//  Data write 0x40, wdata 32'h000000A0, be=4'h3, waitrequest high 3 cycles -> outputs
//   stable 4 cycles; then d_done; RAM word 0x40 low half = 16'h00A0.
//  if_req and d_req same edge, fresh reset -> data granted first, fetch next; repeat
//   both continuously -> grants strictly alternate D,F,D,F.
//  d_req dropped one cycle into BUS -> access completes, d_done pulses, no extra transaction.
//  Reset low during BUS with waitrequest=1 -> read=write=0, busy=0 same cycle, no done.
//  ARB_TIMEOUT_EN, TIMEOUT_CYC=8, waitrequest stuck high -> done after 8 BUS cycles,
//   rdata=32'hDEADBEEF, bus_err=1 until reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the Avalon memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

  localparam logic [3:0]  BE_ALL   = 4'hF;
  localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: req[0] = fetch, req[1] = data.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     last_grant,
  output grant_e     grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = GNT_FETCH;
    // On a tie the requester that did not win last time goes first.
    if (req == 2'b11) begin
      grant = (last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
    end else if (req[1]) begin
      grant = GNT_DATA;
    end
  end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Shares one Avalon-MM master port between instruction fetch and load/store.
// Define ARB_TIMEOUT_EN to add a waitrequest timeout with a sticky bus_err output.
//   state | meaning
//   IDLE  | no transaction; arbitrate pending requests
//   BUS   | strobes asserted, waiting for waitrequest low
//   DONE  | done pulse visible, one idle bus cycle before next grant
module avalon_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_done,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata,
  output logic                busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                bus_err
`endif
);

  arb_state_e            state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  grant_e                gnt_q, gnt_d;
  grant_e                pick;
  logic                  pick_valid;
  logic [ADDR_W-1:0]     address_q, address_d;
  logic [DATA_W-1:0]     writedata_q, writedata_d;
  logic [DATA_W/8-1:0]   byteenable_q, byteenable_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  if_done_q, if_done_d;
  logic                  d_done_q, d_done_d;
  logic                  busy_q, busy_d;
  logic                  finish;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             timeout;

  assign timeout = (wait_cnt_q == '0);
`endif

  arb_rr2 u_rr (
    .req        ({d_req, if_req}),
    .last_grant (last_grant_q),
    .grant      (pick),
    .valid      (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    read_d       = read_q;
    write_d      = write_q;
    rdata_d      = rdata_q;
    busy_d       = busy_q;
    if_done_d    = 1'b0;
    d_done_d     = 1'b0;
    finish       = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    bus_err_d    = bus_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d      = BUS;
          busy_d       = 1'b1;
          gnt_d        = pick;
          last_grant_d = pick;
`ifdef ARB_TIMEOUT_EN
          wait_cnt_d   = CNT_W'(TIMEOUT_CYC - 1);
`endif
          if (pick == GNT_FETCH) begin
            address_d    = if_addr;
            read_d       = 1'b1;
            write_d      = 1'b0;
            byteenable_d = {(DATA_W/32){BE_ALL}};
          end else begin
            address_d    = d_addr;
            read_d       = ~d_we;
            write_d      = d_we;
            writedata_d  = d_wdata;
            byteenable_d = d_be;
          end
        end
      end

      BUS: begin
        if (!waitrequest) begin
          if (read_q) begin
            rdata_d = readdata;
          end
          finish = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (timeout) begin
          // Stuck slave: complete with a recognisable poison value.
          rdata_d   = DATA_W'(DEADBEEF);
          bus_err_d = 1'b1;
          finish    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
`endif
        if (finish) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = DONE;
          if (gnt_q == GNT_FETCH) begin
            if_done_d = 1'b1;
          end else begin
            d_done_d = 1'b1;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_FETCH;
      gnt_q        <= GNT_FETCH;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      rdata_q      <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt_q   <= '0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      read_q       <= read_d;
      write_q      <= write_d;
      rdata_q      <= rdata_d;
      if_done_q    <= if_done_d;
      d_done_q     <= d_done_d;
      busy_q       <= busy_d;
`ifdef ARB_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      bus_err_q    <= bus_err_d;
`endif
    end
  end

  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign read       = read_q;
  assign write      = write_q;
  assign rdata      = rdata_q;
  assign if_done    = if_done_q;
  assign d_done     = d_done_q;
  assign busy       = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign bus_err    = bus_err_q;
`endif

endmodule
